// File: rtl/intersection_phase_scheduler_if.sv
// Signal bundle between the intersection phase scheduler and its controller:
// sensor/preemption inputs in, light and phase status out.
interface intersection_phase_scheduler_if;
    logic [3:0]  req;
    logic        preempt;
    logic [1:0]  preempt_id;
    logic [11:0] lights;
    logic [1:0]  active_id;
    logic [1:0]  phase;
    logic        grant_pulse;

    modport master (
        output req, preempt, preempt_id,
        input  lights, active_id, phase, grant_pulse
    );

    modport slave (
        input  req, preempt, preempt_id,
        output lights, active_id, phase, grant_pulse
    );
endinterface

// File: rtl/intersection_phase_scheduler.sv
// Four-approach traffic phase scheduler: ALL_RED -> GREEN -> YELLOW cycle with
// min/max green, round-robin service and emergency preemption.
module intersection_phase_scheduler #(
    parameter int MIN_GREEN = 8,
    parameter int MAX_GREEN = 32,
    parameter int YELLOW_T  = 4,
    parameter int ALLRED_T  = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    intersection_phase_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        ALL_RED = 2'b00,
        GREEN   = 2'b01,
        YELLOW  = 2'b10
    } state_t;

    // Timer holds (cycles spent in state - 1), so thresholds are compared against N-1.
    localparam logic [5:0] MIN_M1    = 6'(MIN_GREEN - 1);
    localparam logic [5:0] MAX_M1    = 6'(MAX_GREEN - 1);
    localparam logic [5:0] YELLOW_M1 = 6'(YELLOW_T - 1);
    localparam logic [5:0] ALLRED_M1 = 6'(ALLRED_T - 1);
    localparam logic [11:0] ALL_RED_LIGHTS = 12'b100100100100;

    state_t      state, state_nxt;
    logic [5:0]  timer, timer_nxt;
    logic [1:0]  active, active_nxt;
    logic [11:0] lights;
    logic [1:0]  phase;
    logic        grant_pulse;
    logic        other_req;

    function automatic logic [5:0] sat_inc(input logic [5:0] t);
        return (t == 6'h3f) ? t : t + 6'd1;
    endfunction

    // Search last+1, +2, +3, +0; the lowest offset with a request wins.
    function automatic logic [1:0] rr_pick(input logic [1:0] last, input logic [3:0] r);
        logic [1:0] pick;
        logic [1:0] idx;
        pick = last;
        for (int i = 4; i >= 1; i--) begin
            idx = last + 2'(i);
            if (r[idx]) pick = idx;
        end
        return pick;
    endfunction

    function automatic logic [11:0] lights_for(input state_t s, input logic [1:0] id);
        logic [11:0] l;
        int          base;
        l    = ALL_RED_LIGHTS;
        base = 3 * int'(id);
        if (s == GREEN)  l[base +: 3] = 3'b001;
        if (s == YELLOW) l[base +: 3] = 3'b010;
        return l;
    endfunction

    always_comb begin
        state_nxt  = state;
        timer_nxt  = sat_inc(timer);
        active_nxt = active;
        other_req  = |(bus.req & ~(4'b0001 << active));
        case (state)
            ALL_RED: begin
                if (timer >= ALLRED_M1 && (|bus.req || bus.preempt)) begin
                    state_nxt  = GREEN;
                    timer_nxt  = '0;
                    active_nxt = bus.preempt ? bus.preempt_id : rr_pick(active, bus.req);
                end
            end
            GREEN: begin
                if (bus.preempt) begin
                    if (bus.preempt_id != active) begin
                        state_nxt = YELLOW;
                        timer_nxt = '0;
                    end
                end else if (timer >= MIN_M1 && other_req &&
                             (!bus.req[active] || timer >= MAX_M1)) begin
                    state_nxt = YELLOW;
                    timer_nxt = '0;
                end
            end
            YELLOW: begin
                if (timer >= YELLOW_M1) begin
                    state_nxt = ALL_RED;
                    timer_nxt = '0;
                end
            end
            default: begin
                state_nxt = ALL_RED;
                timer_nxt = '0;
            end
        endcase
    end

    // Outputs are registered from the same next-state values the FSM commits.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= ALL_RED;
            timer       <= '0;
            active      <= 2'b11;
            lights      <= ALL_RED_LIGHTS;
            phase       <= 2'b00;
            grant_pulse <= 1'b0;
        end else begin
            state       <= state_nxt;
            timer       <= timer_nxt;
            active      <= active_nxt;
            lights      <= lights_for(state_nxt, active_nxt);
            phase       <= state_nxt;
            grant_pulse <= (state == ALL_RED) && (state_nxt == GREEN);
        end
    end

    assign bus.lights      = lights;
    assign bus.active_id   = active;
    assign bus.phase       = phase;
    assign bus.grant_pulse = grant_pulse;

endmodule

// File: tb/tb_intersection_phase_scheduler.sv
// Directed bench for intersection_phase_scheduler with default parameters.
module tb_intersection_phase_scheduler;

    logic clk;
    logic rst;
    int   total;
    int   bad;
    int   n;

    intersection_phase_scheduler_if bus();

    intersection_phase_scheduler dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [11:0] obs, input logic [11:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // Counts consecutive samples (including the current one) spent in phase p.
    task automatic count_phase(input logic [1:0] p, input int lim, output int cnt);
        cnt = 0;
        while (bus.phase === p && cnt < lim) begin
            cnt++;
            tick();
        end
    endtask

    task automatic wait_grant(input int lim);
        int c;
        c = 0;
        while (bus.grant_pulse !== 1'b1 && c < lim) begin
            tick();
            c++;
        end
    endtask

    task automatic reset_to_green(input logic [3:0] r);
        bus.req = r;
        rst = 1'b0;
        tick();
        rst = 1'b1;
        tick();
        chk("rst_allred1", 12'(bus.phase), 12'h0);
        tick();
        chk("rst_green_phase", 12'(bus.phase), 12'h1);
        chk("rst_green_grant", 12'(bus.grant_pulse), 12'h1);
    endtask

    initial begin
        total = 0;
        bad   = 0;
        rst   = 1'b0;
        bus.req        = 4'b0000;
        bus.preempt    = 1'b0;
        bus.preempt_id = 2'b00;
        tick();
        tick();
        chk("reset_lights", bus.lights, 12'h924);
        chk("reset_phase", 12'(bus.phase), 12'h0);
        chk("reset_active", 12'(bus.active_id), 12'h3);
        chk("reset_grant", 12'(bus.grant_pulse), 12'h0);

        // Single request: green on 0, held indefinitely.
        reset_to_green(4'b0001);
        chk("r031_active", 12'(bus.active_id), 12'h0);
        chk("r031_lights", bus.lights, 12'h921);
        tick();
        chk("r031_grant_off", 12'(bus.grant_pulse), 12'h0);
        count_phase(2'b01, 80, n);
        chk("r031_hold", 12'(n), 12'd80);

        // Competing request with approach 0 still asking: max green.
        reset_to_green(4'b0001);
        bus.req = 4'b0011;
        count_phase(2'b01, 100, n);
        chk("r032_green_len", 12'(n), 12'd32);
        count_phase(2'b10, 20, n);
        chk("r032_yellow_len", 12'(n), 12'd4);
        count_phase(2'b00, 20, n);
        chk("r032_allred_len", 12'(n), 12'd2);
        chk("r032_grant", 12'(bus.grant_pulse), 12'h1);
        chk("r032_active", 12'(bus.active_id), 12'h1);

        // Approach 0 drops its request at k=3: min green applies.
        reset_to_green(4'b0001);
        tick();
        tick();
        bus.req = 4'b0010;
        count_phase(2'b01, 100, n);
        chk("r033_green_rest", 12'(n), 12'd6);
        count_phase(2'b10, 20, n);
        chk("r033_yellow_len", 12'(n), 12'd4);
        count_phase(2'b00, 20, n);
        chk("r033_allred_len", 12'(n), 12'd2);
        chk("r033_active", 12'(bus.active_id), 12'h1);
        chk("r033_lights", bus.lights, 12'h90c);

        // Round-robin from approach 1 with requests on 0, 2, 3.
        bus.req = 4'b1101;
        tick();
        wait_grant(100);
        chk("r034_grant_a", 12'(bus.grant_pulse), 12'h1);
        chk("r034_first", 12'(bus.active_id), 12'h2);
        tick();
        wait_grant(100);
        chk("r034_grant_b", 12'(bus.grant_pulse), 12'h1);
        chk("r034_second", 12'(bus.active_id), 12'h3);
        tick();
        wait_grant(100);
        chk("r034_grant_c", 12'(bus.grant_pulse), 12'h1);
        chk("r034_third", 12'(bus.active_id), 12'h0);

        // Preemption to approach 3 at k=2 of approach 0 green.
        tick();
        bus.preempt    = 1'b1;
        bus.preempt_id = 2'd3;
        tick();
        chk("r035_yellow_now", 12'(bus.phase), 12'h2);
        chk("r035_yellow_lights", bus.lights, 12'h922);
        count_phase(2'b10, 20, n);
        chk("r035_yellow_len", 12'(n), 12'd4);
        count_phase(2'b00, 20, n);
        chk("r035_allred_len", 12'(n), 12'd2);
        chk("r035_active", 12'(bus.active_id), 12'h3);
        chk("r035_grant", 12'(bus.grant_pulse), 12'h1);
        chk("r035_lights", bus.lights, 12'h324);
        count_phase(2'b01, 40, n);
        chk("r035_hold", 12'(n), 12'd40);

        // Release preempt (max green long exceeded), then reset mid-yellow.
        bus.preempt = 1'b0;
        tick();
        chk("r036_yellow", 12'(bus.phase), 12'h2);
        tick();
        #3;
        rst = 1'b0;
        #1;
        chk("r036_async_lights", bus.lights, 12'h924);
        chk("r036_async_phase", 12'(bus.phase), 12'h0);
        chk("r036_async_active", 12'(bus.active_id), 12'h3);
        #1;
        rst = 1'b1;
        tick();
        chk("r036_clear1", 12'(bus.phase), 12'h0);
        tick();
        chk("r036_green", 12'(bus.phase), 12'h1);
        chk("r036_active", 12'(bus.active_id), 12'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/intersection_phase_scheduler.md
INTERSECTION_PHASE_SCHEDULER -- requirements
Module: intersection_phase_scheduler

Interface
REQ-001 Parameter MIN_GREEN, default 8: minimum green duration in cycles.
REQ-002 Parameter MAX_GREEN, default 32: maximum green duration in cycles while a conflicting request is pending.
REQ-003 Parameter YELLOW_T, default 4: yellow duration in cycles.
REQ-004 Parameter ALLRED_T, default 2: all-red clearance duration in cycles.
REQ-005 clk  input  1  clock; all state changes on rising edge.
REQ-006 rst  input  1  reset, asynchronous, active-low.
REQ-007 req  input  4  per-approach vehicle sensor, level-sensitive; bit i = approach i.
REQ-008 preempt  input  1  emergency preemption request, level-sensitive.
REQ-009 preempt_id  input  2  approach to be served while preempt=1.
REQ-010 lights  output  12  registered; bits [3i+2:3i] = approach i; 3'b100 red, 3'b010 yellow, 3'b001 green.
REQ-011 active_id  output  2  registered; approach currently or most recently granted green.
REQ-012 phase  output  2  registered; 2'b00 ALL_RED, 2'b01 GREEN, 2'b10 YELLOW.
REQ-013 grant_pulse  output  1  registered; high for exactly one cycle on each ALL_RED->GREEN entry.

Function
REQ-014 The block SHALL implement three states, ALL_RED, GREEN and YELLOW, using one internal cycle timer of at least 6 bits that is cleared on every state entry.
REQ-015 Lights SHALL be a pure function of registered state: ALL_RED gives 3'b100 on every approach; GREEN/YELLOW give 3'b001/3'b010 on active_id and 3'b100 on all others.
REQ-016 At most one approach SHALL ever be non-red, and no approach SHALL go directly green->red or red->green without passing through yellow and ALL_RED.
REQ-017 ALL_RED SHALL last at least ALLRED_T cycles, after which the block enters GREEN on the next edge if any req bit or preempt is set; otherwise it holds ALL_RED.
REQ-018 Selection at ALL_RED exit: if preempt=1, select preempt_id; otherwise round-robin, searching active_id+1, +2, +3, +0 (mod 4) for the first set req bit.
REQ-019 In GREEN, let k = cycles spent in GREEN including the current one; other_req = any req bit except req[active_id].
REQ-020 GREEN SHALL move to YELLOW when k >= MIN_GREEN and other_req and (req[active_id]=0 or k >= MAX_GREEN); otherwise it holds GREEN, resting indefinitely when other_req=0.
REQ-021 Preemption override: in GREEN with preempt=1 and preempt_id != active_id, the block SHALL move to YELLOW on the next edge regardless of k.
REQ-022 In GREEN with preempt=1 and preempt_id = active_id, the block SHALL hold GREEN and ignore REQ-020.
REQ-023 YELLOW SHALL last exactly YELLOW_T cycles, then ALL_RED; preempt changes during YELLOW or ALL_RED SHALL NOT shorten either.
REQ-024 If preempt is deasserted before ALL_RED exit, selection SHALL revert to round-robin.
REQ-025 active_id SHALL update only on ALL_RED->GREEN entry.
REQ-026 Timer SHALL saturate rather than wrap while holding ALL_RED or resting on GREEN.
REQ-027 Parameter legality: 1 <= YELLOW_T, 1 <= ALLRED_T, 1 <= MIN_GREEN <= MAX_GREEN <= 63; other values are unsupported.

Reset
REQ-028 While rst=0, the block SHALL be in ALL_RED with timer=0, active_id=2'b11, lights=12'b100100100100, phase=2'b00 and grant_pulse=0.
REQ-029 Asserting rst mid-phase SHALL force the REQ-028 values immediately, without a yellow interval.
REQ-030 After rst deasserts, the full ALLRED_T clearance SHALL elapse before any green.

Verification
REQ-031 Reset release, req=4'b0001 held: ALL_RED for 2 cycles, then GREEN on approach 0 with grant_pulse for 1 cycle; green held indefinitely.
REQ-032 Approach 0 green, req=4'b0011 held: green for exactly 32 cycles, yellow 4, all-red 2, then green on approach 1 with active_id=1.
REQ-033 Approach 0 green, req changes to 4'b0010 at k=3: green ends after k=8, then yellow 4, all-red 2, green on approach 1.
REQ-034 Round-robin fairness: active_id=1, req=4'b1101 at ALL_RED exit -> approach 2 selected; next grant goes to approach 3, then 0.
REQ-035 Approach 0 green at k=2, preempt=1 with preempt_id=3: YELLOW on the next edge, 4 yellow, 2 all-red, then green on approach 3, held while preempt=1.
REQ-036 Reset asserted mid-yellow: lights go to all 100 and phase to 00 asynchronously; after release, 2 all-red cycles precede any green.
